// File: rtl/limb_mac_sched_pkg.sv
// Shared cp_cluster constants for the limb multiply-add sequencer.
// Limb/product widths, the limb type and the controller state encoding.
package limb_mac_sched_pkg;

   localparam int LIMB_W = 18;
   localparam int MAC_W  = 36;

   typedef logic [LIMB_W-1:0] limb_t;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_FINAL = 2'd3;

endpackage

// File: rtl/limb_mac_sched_if.sv
// Command and limb-RAM bundle of the limb multiply-add sequencer.
// master = cluster/RAM side, slave = the sequencer.
interface limb_mac_sched_if #(
   parameter int ADDR_WIDTH = 4
);
   import limb_mac_sched_pkg::*;

   logic                  start;
   limb_t                 b;
   limb_t                 k;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   limb_t                 rd_data;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   limb_t                 wr_data;
   logic                  busy;
   logic                  done;

   modport master (
      output start, b, k, rd_data,
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
   );

   modport slave (
      input  start, b, k, rd_data,
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
   );

endinterface

// File: rtl/limb_mac_sched_mac.sv
// Shared 18x18+18 multiply-add unit with registered 36-bit result.
// sclr has priority over ce; p holds its value while ce is low.
module mult_add_18_type0
   import limb_mac_sched_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             sclr,
   input  limb_t            a,
   input  limb_t            b,
   input  limb_t            c,
   output logic [MAC_W-1:0] p
);

   // Product register: clear, load a*b+c, or hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         p <= '0;
      else if (sclr)
         p <= '0;
      else if (ce)
         p <= MAC_W'(a) * MAC_W'(b) + MAC_W'(c);
   end

endmodule

// File: rtl/limb_mac_sched.sv
// Sequencer for R = A*b + k, one 18-bit limb per cycle on the shared MAC.
// The MAC p register carries the limb carry between issues.
module limb_mac_sched
   import limb_mac_sched_pkg::*;
#(
   parameter int NUM_LIMBS  = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   limb_mac_sched_if.slave bus
);

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_LIMBS - 1);
   localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

   logic [1:0]            state;
   logic                  rd_en_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic                  rvalid;
   logic                  first;
   logic                  wr_q;
   logic [ADDR_WIDTH-1:0] wa;
   limb_t                 b_q;
   limb_t                 k_q;
   logic [MAC_W-1:0]      p;
   limb_t                 mac_c;
   logic                  accept;
   logic                  fin;

   assign accept = (state == S_IDLE) && bus.start;
   assign fin    = (state == S_FINAL);
   assign mac_c  = first ? k_q : p[MAC_W-1:LIMB_W];

   mult_add_18_type0 u_mac (
      .clk  (clk),
      .rst  (rst),
      .ce   (rvalid),
      .sclr (accept),
      .a    (bus.rd_data),
      .b    (b_q),
      .c    (mac_c),
      .p    (p)
   );

   // Control FSM: leave RUN once the last limb write is on the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:  if (bus.start) state <= S_FETCH;
            S_FETCH: state <= S_RUN;
            S_RUN:   if (wr_q && wa == LAST) state <= S_FINAL;
            S_FINAL: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Operand read strobe walks limbs 0..N-1 on consecutive cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
      end else if (accept) begin
         rd_en_q   <= 1'b1;
         rd_addr_q <= '0;
      end else if (rd_en_q) begin
         if (rd_addr_q == LAST) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
         end else begin
            rd_addr_q <= rd_addr_q + ONE;
         end
      end
   end

   // Read-data valid drives MAC issue; issue delayed once is a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid <= 1'b0;
         wr_q   <= 1'b0;
         first  <= 1'b0;
      end else begin
         rvalid <= rd_en_q;
         wr_q   <= rvalid;
         if (accept)
            first <= 1'b1;
         else if (rvalid)
            first <= 1'b0;
      end
   end

   // Result address counts writes; reaches N for the carry write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wa <= '0;
      else if (accept || fin)
         wa <= '0;
      else if (wr_q)
         wa <= wa + ONE;
   end

   // Scalars captured on accept so later input changes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_q <= '0;
         k_q <= '0;
      end else if (accept) begin
         b_q <= bus.b;
         k_q <= bus.k;
      end
   end

   assign bus.rd_en   = rd_en_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.wr_en   = wr_q | fin;
   assign bus.wr_addr = wa;
   assign bus.wr_data = fin  ? p[MAC_W-1:LIMB_W] :
                        wr_q ? p[LIMB_W-1:0]     : '0;
   assign bus.busy    = (state != S_IDLE);
   assign bus.done    = fin;

endmodule
